// File: rtl/cmos_cap_pkg.sv
// Shared types and constants for the camera snapshot capture path.
package cmos_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

  localparam int unsigned GRAY_R_COEF = 77;
  localparam int unsigned GRAY_G_COEF = 150;
  localparam int unsigned GRAY_B_COEF = 29;

  localparam int unsigned DEF_H_CMOS_DISP = 1024;
  localparam int unsigned DEF_V_CMOS_DISP = 768;
  localparam int unsigned DEF_WIN_X0      = 384;
  localparam int unsigned DEF_WIN_Y0      = 352;
  localparam int unsigned DEF_WIN_W       = 256;
  localparam int unsigned DEF_WIN_H       = 64;
  localparam int unsigned DEF_ADDR_W      = 12;
  localparam int unsigned WORD_COUNT      = DEF_WIN_W * DEF_WIN_H / 4;

  // Bit-replicating channel expansion to 8 bits.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/cmos_frame_capture_rgb565_to_gray.sv
// Two-stage RGB565 -> 8-bit gray pipeline with valid/last passthrough.
module rgb565_to_gray
  import cmos_cap_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [15:0] in_data,
  output logic        out_valid,
  output logic        out_last,
  output logic [7:0]  out_gray
);

  logic [15:0] r_prod;
  logic [15:0] g_prod;
  logic [15:0] b_prod;
  logic        s1_valid;
  logic        s1_last;
  logic [16:0] sum_c;

  assign sum_c = 17'(r_prod) + 17'(g_prod) + 17'(b_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod    <= '0;
      g_prod    <= '0;
      b_prod    <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      out_gray  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      r_prod    <= 16'(expand5(in_data[15:11])) * 16'(GRAY_R_COEF);
      g_prod    <= 16'(expand6(in_data[10:5]))  * 16'(GRAY_G_COEF);
      b_prod    <= 16'(expand5(in_data[4:0]))   * 16'(GRAY_B_COEF);
      s1_valid  <= in_valid;
      s1_last   <= in_valid & in_last;
      // Coefficients sum to 256, so the shifted sum always fits 8 bits.
      out_gray  <= 8'(sum_c >> 8);
      out_valid <= s1_valid;
      out_last  <= s1_last;
    end
  end

endmodule

// File: rtl/cmos_frame_capture.sv
// Snapshot capture: crops a window of the camera stream, converts to gray and
// packs four pixels per word into the frame RAM, once per CPU request.
module cmos_frame_capture
  import cmos_cap_pkg::*;
#(
  parameter int unsigned H_CMOS_DISP = DEF_H_CMOS_DISP,
  parameter int unsigned V_CMOS_DISP = DEF_V_CMOS_DISP,
  parameter int unsigned WIN_X0      = DEF_WIN_X0,
  parameter int unsigned WIN_Y0      = DEF_WIN_Y0,
  parameter int unsigned WIN_W       = DEF_WIN_W,
  parameter int unsigned WIN_H       = DEF_WIN_H,
  parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmos_frame_vsync,
  input  logic              cmos_frame_valid,
  input  logic [15:0]       cmos_frame_data,
  input  logic              cap_start,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);

  localparam int unsigned X_W = $clog2(H_CMOS_DISP);
  localparam int unsigned Y_W = $clog2(V_CMOS_DISP);

  cap_state_e        state;
  logic              vs_d;
  logic              vs_rise_c;
  logic [X_W-1:0]    x_cnt;
  logic [Y_W-1:0]    y_cnt;
  logic              in_win_c;
  logic              last_pix_c;
  logic              capturing_c;
  logic              enter_cap_c;
  logic              g_valid;
  logic              g_last;
  logic [7:0]        g_gray;
  logic [1:0]        lane;
  logic [23:0]       pack_q;
  logic [31:0]       word_q;
  logic              word_vld;
  logic              word_last;
  logic              mem_last;
  logic [ADDR_W-1:0] wr_addr;

  assign vs_rise_c   = cmos_frame_vsync & ~vs_d;
  assign capturing_c = (state == ST_CAPTURE);
  assign enter_cap_c = (state == ST_WAIT_VS) && vs_rise_c;

  assign in_win_c = cmos_frame_valid
                 && (32'(x_cnt) >= WIN_X0) && (32'(x_cnt) < WIN_X0 + WIN_W)
                 && (32'(y_cnt) >= WIN_Y0) && (32'(y_cnt) < WIN_Y0 + WIN_H);
  assign last_pix_c = (32'(x_cnt) == WIN_X0 + WIN_W - 1)
                   && (32'(y_cnt) == WIN_Y0 + WIN_H - 1);

  // Raster position; y holds at the last line so overrun pixels stay outside the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d  <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      vs_d <= cmos_frame_vsync;
      if (vs_rise_c) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (cmos_frame_valid) begin
        if (x_cnt == X_W'(H_CMOS_DISP - 1)) begin
          x_cnt <= '0;
          if (y_cnt != Y_W'(V_CMOS_DISP - 1)) y_cnt <= y_cnt + Y_W'(1);
        end else begin
          x_cnt <= x_cnt + X_W'(1);
        end
      end
    end
  end

  rgb565_to_gray u_gray (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_win_c & capturing_c),
    .in_last   (last_pix_c),
    .in_data   (cmos_frame_data),
    .out_valid (g_valid),
    .out_last  (g_last),
    .out_gray  (g_gray)
  );

  // Lane packing; the fourth gray pixel completes a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane      <= '0;
      pack_q    <= '0;
      word_q    <= '0;
      word_vld  <= 1'b0;
      word_last <= 1'b0;
    end else if (enter_cap_c) begin
      lane      <= '0;
      word_vld  <= 1'b0;
      word_last <= 1'b0;
    end else begin
      word_vld  <= 1'b0;
      word_last <= 1'b0;
      if (g_valid && capturing_c) begin
        case (lane)
          2'd0: pack_q[7:0]   <= g_gray;
          2'd1: pack_q[15:8]  <= g_gray;
          2'd2: pack_q[23:16] <= g_gray;
          default: begin
            word_q    <= {g_gray, pack_q};
            word_vld  <= 1'b1;
            word_last <= g_last;
          end
        endcase
        lane <= lane + 2'd1;
      end
    end
  end

  // RAM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_last  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_addr   <= '0;
    end else if (enter_cap_c) begin
      mem_we   <= 1'b0;
      mem_last <= 1'b0;
      wr_addr  <= '0;
    end else begin
      mem_we   <= word_vld;
      mem_last <= word_vld & word_last;
      if (word_vld) begin
        mem_wdata <= word_q;
        mem_addr  <= wr_addr;
        wr_addr   <= wr_addr + ADDR_W'(1);
      end
    end
  end

  // Request handshake; a frame is only captured from its start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cap_busy <= 1'b0;
      cap_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cap_start) begin
            state    <= ST_WAIT_VS;
            cap_busy <= 1'b1;
            cap_done <= 1'b0;
          end
        end
        ST_WAIT_VS: begin
          if (vs_rise_c) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (mem_we && mem_last) state <= ST_DONE;
          else if (vs_rise_c)     state <= ST_WAIT_VS;
        end
        ST_DONE: begin
          cap_done <= 1'b1;
          cap_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_frame_capture.sv
// Scoreboard bench for cmos_frame_capture on a scaled-down raster.
module tb_cmos_frame_capture;

  localparam int TH  = 32;
  localparam int TV  = 24;
  localparam int TX0 = 8;
  localparam int TY0 = 6;
  localparam int TW  = 16;
  localparam int TWH = 4;
  localparam int TAW = 12;
  localparam int NW  = TW * TWH / 4;

  typedef struct packed {
    logic [TAW-1:0] addr;
    logic [31:0]    data;
  } wr_t;

  logic           clk;
  logic           rst_n;
  logic           cmos_frame_vsync;
  logic           cmos_frame_valid;
  logic [15:0]    cmos_frame_data;
  logic           cap_start;
  logic           cap_busy;
  logic           cap_done;
  logic           mem_we;
  logic [TAW-1:0] mem_addr;
  logic [31:0]    mem_wdata;

  int  checks   = 0;
  int  failures = 0;
  int  n_writes = 0;
  wr_t exp_q[$];

  cmos_frame_capture #(
    .H_CMOS_DISP (TH),
    .V_CMOS_DISP (TV),
    .WIN_X0      (TX0),
    .WIN_Y0      (TY0),
    .WIN_W       (TW),
    .WIN_H       (TWH),
    .ADDR_W      (TAW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmos_frame_vsync (cmos_frame_vsync),
    .cmos_frame_valid (cmos_frame_valid),
    .cmos_frame_data  (cmos_frame_data),
    .cap_start        (cap_start),
    .cap_busy         (cap_busy),
    .cap_done         (cap_done),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference gray value straight from the channel expansion and weights.
  function automatic int gray_of(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    r = (r << 3) | (r >> 2);
    g = (g << 2) | (g >> 4);
    b = (b << 3) | (b >> 2);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  function automatic logic [15:0] pixel_of(input int mode, input int x);
    logic [15:0] cyc [4];
    cyc[0] = 16'hF800; cyc[1] = 16'h07E0; cyc[2] = 16'h001F; cyc[3] = 16'h0000;
    case (mode)
      0:       return 16'hFFFF;
      1:       return cyc[x % 4];
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: every write must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%0d data=%h required=none", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    tick();
  endtask

  // One frame of `lines` lines; `cap` says whether this frame is expected to be stored.
  task automatic drive_frame(input int mode, input bit cap, input int lines,
                             input bit start_with_vs, input int start_after_line);
    int          lane = 0;
    int          addr = 0;
    logic [31:0] word = '0;
    logic [15:0] pix;
    cmos_frame_vsync = 1'b1;
    cap_start = start_with_vs;
    tick();
    cap_start = 1'b0;
    repeat (3) tick();
    cmos_frame_vsync = 1'b0;
    repeat (4) tick();
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < TH; x++) begin
        pix = pixel_of(mode, x);
        cmos_frame_valid = 1'b1;
        cmos_frame_data  = pix;
        if (cap && x >= TX0 && x < TX0 + TW && y >= TY0 && y < TY0 + TWH) begin
          word[8*lane +: 8] = 8'(gray_of(pix));
          lane++;
          if (lane == 4) begin
            exp_q.push_back('{addr: TAW'(addr), data: word});
            addr++;
            lane = 0;
          end
        end
        tick();
      end
      cmos_frame_valid = 1'b0;
      cmos_frame_data  = 16'($urandom);
      if (y == start_after_line) begin
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
      end
      repeat (4) tick();
    end
    repeat (8) tick();
  endtask

  task automatic expect_done(input string tag);
    int n = 0;
    while (!cap_done && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(cap_done), 32'd1);
    check({tag, "_busy"}, 32'(cap_busy), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},    32'(mem_we),    32'd0);
    check({tag, "_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_wdata"}, mem_wdata,      32'd0);
    check({tag, "_busy"},  32'(cap_busy),  32'd0);
    check({tag, "_done"},  32'(cap_done),  32'd0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    cmos_frame_vsync = 1'b0;
    cmos_frame_valid = 1'b0;
    cmos_frame_data  = '0;
    cap_start = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // White frames: only the first frame after the request is stored.
    pulse_start();
    check("busy_after_start", 32'(cap_busy), 32'd1);
    drive_frame(0, 1'b1, TV, 1'b0, -1);
    expect_done("white");
    drive_frame(0, 1'b0, TV, 1'b0, -1);
    check("white_write_count", 32'(n_writes), 32'(NW));

    // Request coincident with frame start: capture starts one frame later.
    drive_frame(1, 1'b0, TV, 1'b1, -1);
    check("vs_start_busy", 32'(cap_busy), 32'd1);
    base = n_writes;
    drive_frame(1, 1'b1, TV, 1'b0, -1);
    expect_done("colour");
    check("colour_write_count", 32'(n_writes - base), 32'(NW));

    // Mid-frame request waits for the next frame start.
    base = n_writes;
    drive_frame(2, 1'b0, TV, 1'b0, 2);
    check("midstart_no_writes", 32'(n_writes - base), 32'd0);
    drive_frame(2, 1'b1, TV, 1'b0, -1);
    expect_done("midstart");

    // Short frame: partial words, then the abort frame is skipped, then a full restart.
    pulse_start();
    drive_frame(2, 1'b1, TY0 + 1, 1'b0, -1);
    drive_frame(2, 1'b0, TV, 1'b0, -1);
    check("short_busy", 32'(cap_busy), 32'd1);
    base = n_writes;
    drive_frame(2, 1'b1, TV, 1'b0, -1);
    expect_done("short");
    check("short_restart_count", 32'(n_writes - base), 32'(NW));

    // Request while busy is ignored; addresses keep counting.
    pulse_start();
    drive_frame(2, 1'b1, TV, 1'b0, TY0 + 1);
    expect_done("busyreq");
    base = n_writes;
    drive_frame(2, 1'b0, TV, 1'b0, -1);
    check("busyreq_no_extra", 32'(n_writes - base), 32'd0);

    // Reset in the middle of a capture.
    pulse_start();
    drive_frame(2, 1'b1, TY0 + 2, 1'b0, -1);
    check("pre_reset_queue", 32'(exp_q.size()), 32'd0);
    check("pre_reset_busy", 32'(cap_busy), 32'd1);
    rst_n = 1'b0;
    #2;
    check_idle_outputs("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    base = n_writes;
    drive_frame(2, 1'b0, TV, 1'b0, -1);
    check("post_reset_no_writes", 32'(n_writes - base), 32'd0);
    check("post_reset_done", 32'(cap_done), 32'd0);
    check("post_reset_busy", 32'(cap_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
